// File: rtl/ordered_id_queue_pkg.sv
// Shared helpers for the ordered ID queue and its priority encoders.
package ordered_id_queue_pkg;

    // Index width needed to address n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/lzc.sv
// Priority encoder: index of the lowest set bit (MODE=0) or number of
// leading zeros (MODE=1); empty_o flags an all-zero input.
module lzc
    import ordered_id_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CNT_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    // Scan so that the winning bit is the last one written.
    always_comb begin
        cnt_o = '0;
        if (!MODE) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/onehot_to_bin.sv
// One-hot to binary index converter; the input is assumed one-hot or zero.
module onehot_to_bin
    import ordered_id_queue_pkg::*;
#(
    parameter int unsigned ONEHOT_WIDTH = 16,
    localparam int unsigned BIN_WIDTH   = idx_width(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output logic [BIN_WIDTH-1:0]    bin
);

    // OR together the indices of all set bits.
    always_comb begin
        bin = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot[i]) bin = bin | BIN_WIDTH'(i);
        end
    end

endmodule

// File: rtl/ordered_id_queue.sv
// Fixed-capacity queue keeping FIFO order per ID. A head-tail table holds one
// linked list per live ID; the linked-data table holds the elements.
module ordered_id_queue
    import ordered_id_queue_pkg::*;
#(
    parameter int unsigned ID_WIDTH            = 2,
    parameter int unsigned CAPACITY            = 4,
    parameter bit          FULL_BW             = 1'b0,
    parameter bit          CUT_OUP_POP_INP_GNT = 1'b0,
    parameter type         data_t              = logic [31:0]
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_WIDTH-1:0] inp_id_i,
    input  data_t               inp_data_i,
    input  logic                inp_req_i,
    output logic                inp_gnt_o,
    input  data_t               exists_data_i,
    input  data_t               exists_mask_i,
    input  logic                exists_req_i,
    output logic                exists_o,
    output logic                exists_gnt_o,
    input  logic [ID_WIDTH-1:0] oup_id_i,
    input  logic                oup_pop_i,
    input  logic                oup_req_i,
    output data_t               oup_data_o,
    output logic                oup_data_valid_o,
    output logic                oup_gnt_o
);

    localparam int unsigned HT_CAP = ((2 ** ID_WIDTH) < CAPACITY) ? (2 ** ID_WIDTH) : CAPACITY;
    localparam int unsigned HT_W   = idx_width(HT_CAP);
    localparam int unsigned LD_W   = idx_width(CAPACITY);

    if (ID_WIDTH == 0) begin : g_bad_id_width
        $fatal(1, "ordered_id_queue: ID_WIDTH must be at least 1");
    end
    if (CAPACITY == 0) begin : g_bad_capacity
        $fatal(1, "ordered_id_queue: CAPACITY must be at least 1");
    end

    typedef logic [HT_W-1:0] ht_idx_t;
    typedef logic [LD_W-1:0] ld_idx_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        ld_idx_t             head;
        ld_idx_t             tail;
        logic                free;
    } ht_t;

    typedef struct packed {
        data_t   data;
        ld_idx_t next;
        logic    free;
    } ld_t;

    ht_t ht_q [HT_CAP];
    ht_t ht_d [HT_CAP];
    ld_t ld_q [CAPACITY];
    ld_t ld_d [CAPACITY];

    logic [HT_CAP-1:0]   ht_free, inp_match, oup_match;
    logic [CAPACITY-1:0] ld_free, exists_match;
    ht_idx_t             ht_free_idx, inp_ht_idx, oup_ht_idx, ht_new_idx;
    ld_idx_t             ld_free_idx, ld_new_idx, oup_head;
    logic                ht_none_free, full;
    logic                inp_hit, oup_hit, serve, pop, pop_frees_ht, push, push_new;

    // Per-entry flags: free slots, ID matches and masked exists matches.
    always_comb begin
        for (int i = 0; i < HT_CAP; i++) begin
            ht_free[i]   = ht_q[i].free;
            inp_match[i] = !ht_q[i].free && (ht_q[i].id == inp_id_i);
            oup_match[i] = !ht_q[i].free && (ht_q[i].id == oup_id_i);
        end
        for (int i = 0; i < CAPACITY; i++) begin
            ld_free[i]      = ld_q[i].free;
            exists_match[i] = !ld_q[i].free &&
                              (((ld_q[i].data ^ exists_data_i) & exists_mask_i) == '0);
        end
    end

    lzc #(.WIDTH(HT_CAP), .MODE(1'b0)) i_ht_free_lzc (
        .in_i    (ht_free),
        .cnt_o   (ht_free_idx),
        .empty_o (ht_none_free)
    );

    lzc #(.WIDTH(CAPACITY), .MODE(1'b0)) i_ld_free_lzc (
        .in_i    (ld_free),
        .cnt_o   (ld_free_idx),
        .empty_o (full)
    );

    onehot_to_bin #(.ONEHOT_WIDTH(HT_CAP)) i_inp_id_bin (
        .onehot (inp_match),
        .bin    (inp_ht_idx)
    );

    onehot_to_bin #(.ONEHOT_WIDTH(HT_CAP)) i_oup_id_bin (
        .onehot (oup_match),
        .bin    (oup_ht_idx)
    );

    assign inp_hit  = |inp_match;
    assign oup_hit  = |oup_match;
    assign oup_head = ht_q[oup_ht_idx].head;

    // Without full bandwidth an accepted push blocks the output port this cycle.
    assign serve        = oup_req_i && (FULL_BW || !(inp_req_i && !full));
    assign pop          = serve && oup_pop_i && oup_hit;
    assign pop_frees_ht = pop && (ht_q[oup_ht_idx].head == ht_q[oup_ht_idx].tail);
    assign inp_gnt_o    = !full || (FULL_BW && !CUT_OUP_POP_INP_GNT && pop);
    assign push         = inp_req_i && inp_gnt_o;

    // A same-cycle push reuses the popped slot; an ID whose only element is
    // popped is treated as new so its freed head-tail entry is re-populated.
    assign push_new   = !inp_hit || (pop_frees_ht && (inp_ht_idx == oup_ht_idx));
    assign ld_new_idx = pop ? oup_head : ld_free_idx;
    assign ht_new_idx = (pop_frees_ht || ht_none_free) ? oup_ht_idx : ht_free_idx;

    assign oup_gnt_o        = serve;
    assign oup_data_valid_o = serve && oup_hit;
    assign oup_data_o       = (serve && oup_hit) ? ld_q[oup_head].data : data_t'('0);
    assign exists_gnt_o     = exists_req_i;
    assign exists_o         = exists_req_i && (|exists_match);

    // Table next state: apply the pop first, then let the push overwrite.
    always_comb begin
        ht_d = ht_q;
        ld_d = ld_q;
        if (pop) begin
            ld_d[oup_head].free = 1'b1;
            if (pop_frees_ht) begin
                ht_d[oup_ht_idx].free = 1'b1;
            end else begin
                ht_d[oup_ht_idx].head = ld_q[oup_head].next;
            end
        end
        if (push) begin
            ld_d[ld_new_idx] = '{data: inp_data_i, next: '0, free: 1'b0};
            if (push_new) begin
                ht_d[ht_new_idx] = '{id: inp_id_i, head: ld_new_idx, tail: ld_new_idx, free: 1'b0};
            end else begin
                ld_d[ht_q[inp_ht_idx].tail].next = ld_new_idx;
                ht_d[inp_ht_idx].tail            = ld_new_idx;
            end
        end
    end

    // Table registers; reset empties both tables at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < HT_CAP; i++) begin
                ht_q[i] <= '{id: '0, head: '0, tail: '0, free: 1'b1};
            end
            for (int i = 0; i < CAPACITY; i++) begin
                ld_q[i] <= '{data: '0, next: '0, free: 1'b1};
            end
        end else begin
            ht_q <= ht_d;
            ld_q <= ld_d;
        end
    end

endmodule

// File: tb/tb_ordered_id_queue.sv
// Bench for ordered_id_queue: a FULL_BW=0 and a FULL_BW=1 instance share all
// inputs and are compared against a per-ID list model, after directed vectors.
module tb_ordered_id_queue;

    localparam int CAP = 4;

    logic        clk, rst_n;
    logic [1:0]  inp_id, oup_id;
    logic [31:0] inp_data, ex_data, ex_mask;
    logic        inp_req, oup_req, oup_pop, ex_req;

    logic        igt0, ogt0, vld0, ex0, exg0;
    logic [31:0] od0;
    logic        igt1, ogt1, vld1, ex1, exg1;
    logic [31:0] od1;

    int total = 0;
    int bad   = 0;

    // Reference model: element list per ID for each instance (0: !FULL_BW, 1: FULL_BW).
    logic [31:0] mdata [2][4][CAP];
    int          mcnt  [2][4];

    typedef struct {
        logic        ireq;
        logic [1:0]  iid;
        logic [31:0] idata;
        logic        oreq;
        logic [1:0]  oid;
        logic        pop;
        logic        ereq;
        logic [31:0] edata;
        logic [31:0] emask;
        logic        e_igt;
        logic        e_ogt;
        logic        e_vld;
        logic [31:0] e_od;
        logic        e_ex;
    } vec_t;

    vec_t tv [28];

    ordered_id_queue #(.ID_WIDTH(2), .CAPACITY(CAP), .FULL_BW(1'b0), .CUT_OUP_POP_INP_GNT(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .inp_id_i(inp_id), .inp_data_i(inp_data), .inp_req_i(inp_req), .inp_gnt_o(igt0),
        .exists_data_i(ex_data), .exists_mask_i(ex_mask), .exists_req_i(ex_req),
        .exists_o(ex0), .exists_gnt_o(exg0),
        .oup_id_i(oup_id), .oup_pop_i(oup_pop), .oup_req_i(oup_req),
        .oup_data_o(od0), .oup_data_valid_o(vld0), .oup_gnt_o(ogt0)
    );

    ordered_id_queue #(.ID_WIDTH(2), .CAPACITY(CAP), .FULL_BW(1'b1), .CUT_OUP_POP_INP_GNT(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .inp_id_i(inp_id), .inp_data_i(inp_data), .inp_req_i(inp_req), .inp_gnt_o(igt1),
        .exists_data_i(ex_data), .exists_mask_i(ex_mask), .exists_req_i(ex_req),
        .exists_o(ex1), .exists_gnt_o(exg1),
        .oup_id_i(oup_id), .oup_pop_i(oup_pop), .oup_req_i(oup_req),
        .oup_data_o(od1), .oup_data_valid_o(vld1), .oup_gnt_o(ogt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ireq, input logic [1:0] iid, input logic [31:0] idata,
                                input logic oreq, input logic [1:0] oid, input logic pop,
                                input logic ereq, input logic [31:0] edata, input logic [31:0] emask,
                                input logic e_igt, input logic e_ogt, input logic e_vld,
                                input logic [31:0] e_od, input logic e_ex);
        vec_t v;
        v.ireq = ireq; v.iid = iid; v.idata = idata;
        v.oreq = oreq; v.oid = oid; v.pop = pop;
        v.ereq = ereq; v.edata = edata; v.emask = emask;
        v.e_igt = e_igt; v.e_ogt = e_ogt; v.e_vld = e_vld; v.e_od = e_od; v.e_ex = e_ex;
        return v;
    endfunction

    task automatic idle_inputs();
        inp_req = 1'b0; inp_id = 2'd0; inp_data = 32'd0;
        oup_req = 1'b0; oup_id = 2'd0; oup_pop = 1'b0;
        ex_req = 1'b0; ex_data = 32'd0; ex_mask = 32'd0;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 4; k++) mcnt[m][k] = 0;
    endtask

    // Check both instances against the model for the current inputs, then
    // advance the model by what this cycle's edge will commit.
    task automatic check_model(input string tag);
        int          cnt;
        logic        full, hit, e_ogt, e_vld, e_igt, e_ex, dpop, dpush;
        logic [31:0] e_od;
        logic        a_igt, a_ogt, a_vld, a_ex, a_exg;
        logic [31:0] a_od;
        for (int m = 0; m < 2; m++) begin
            cnt = 0;
            for (int k = 0; k < 4; k++) cnt += mcnt[m][k];
            full  = (cnt == CAP);
            hit   = (mcnt[m][oup_id] > 0);
            e_ogt = (m == 0) ? (oup_req && !(inp_req && !full)) : oup_req;
            e_vld = e_ogt && hit;
            e_od  = e_vld ? mdata[m][oup_id][0] : 32'd0;
            dpop  = e_vld && oup_pop;
            e_igt = !full || (m == 1 && dpop);
            dpush = inp_req && e_igt;
            e_ex  = 1'b0;
            if (ex_req)
                for (int k = 0; k < 4; k++)
                    for (int j = 0; j < mcnt[m][k]; j++)
                        if (((mdata[m][k][j] ^ ex_data) & ex_mask) == 32'd0) e_ex = 1'b1;
            a_igt = (m == 0) ? igt0 : igt1;
            a_ogt = (m == 0) ? ogt0 : ogt1;
            a_vld = (m == 0) ? vld0 : vld1;
            a_od  = (m == 0) ? od0  : od1;
            a_ex  = (m == 0) ? ex0  : ex1;
            a_exg = (m == 0) ? exg0 : exg1;
            chk($sformatf("%s.bw%0d.inp_gnt", tag, m), {31'd0, a_igt}, {31'd0, e_igt});
            chk($sformatf("%s.bw%0d.oup_gnt", tag, m), {31'd0, a_ogt}, {31'd0, e_ogt});
            chk($sformatf("%s.bw%0d.valid", tag, m), {31'd0, a_vld}, {31'd0, e_vld});
            chk($sformatf("%s.bw%0d.data", tag, m), a_od, e_od);
            chk($sformatf("%s.bw%0d.exists", tag, m), {31'd0, a_ex}, {31'd0, e_ex});
            chk($sformatf("%s.bw%0d.exists_gnt", tag, m), {31'd0, a_exg}, {31'd0, ex_req});
            if (dpop) begin
                for (int j = 0; j < mcnt[m][oup_id] - 1; j++)
                    mdata[m][oup_id][j] = mdata[m][oup_id][j+1];
                mcnt[m][oup_id]--;
            end
            if (dpush) begin
                mdata[m][inp_id][mcnt[m][inp_id]] = inp_data;
                mcnt[m][inp_id]++;
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] id, input logic [31:0] d);
        idle_inputs();
        inp_req = 1'b1; inp_id = id; inp_data = d;
        step("push");
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".inp_gnt0"}, {31'd0, igt0}, 32'd1);
        chk({tag, ".inp_gnt1"}, {31'd0, igt1}, 32'd1);
        chk({tag, ".oup_gnt0"}, {31'd0, ogt0}, 32'd0);
        chk({tag, ".valid1"}, {31'd0, vld1}, 32'd0);
        chk({tag, ".data0"}, od0, 32'd0);
        chk({tag, ".exists0"}, {31'd0, ex0}, 32'd0);
        chk({tag, ".exists_gnt1"}, {31'd0, exg1}, 32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();

        // Directed vectors; expected columns describe the FULL_BW=0 instance.
        tv[0]  = mk(0,0,0,        0,0,0, 0,0,0,            1,0,0,0,0);
        tv[1]  = mk(1,1,'hA,      0,0,0, 0,0,0,            1,0,0,0,0);
        tv[2]  = mk(1,1,'hB,      0,0,0, 0,0,0,            1,0,0,0,0);
        tv[3]  = mk(1,1,'hC,      0,0,0, 0,0,0,            1,0,0,0,0);
        tv[4]  = mk(0,0,0,        1,1,1, 0,0,0,            1,1,1,'hA,0);
        tv[5]  = mk(0,0,0,        1,1,1, 0,0,0,            1,1,1,'hB,0);
        tv[6]  = mk(0,0,0,        1,1,1, 0,0,0,            1,1,1,'hC,0);
        tv[7]  = mk(0,0,0,        1,1,1, 0,0,0,            1,1,0,0,0);
        tv[8]  = mk(1,0,'h10,     0,0,0, 0,0,0,            1,0,0,0,0);
        tv[9]  = mk(1,1,'h20,     0,0,0, 0,0,0,            1,0,0,0,0);
        tv[10] = mk(1,0,'h11,     0,0,0, 0,0,0,            1,0,0,0,0);
        tv[11] = mk(0,0,0,        1,1,1, 0,0,0,            1,1,1,'h20,0);
        tv[12] = mk(0,0,0,        1,0,1, 0,0,0,            1,1,1,'h10,0);
        tv[13] = mk(0,0,0,        1,0,1, 0,0,0,            1,1,1,'h11,0);
        for (int k = 0; k < 4; k++)
            tv[14+k] = mk(1,2,32'h30 + k, 0,0,0, 0,0,0,   1,0,0,0,0);
        tv[18] = mk(1,2,'h99,     0,0,0, 0,0,0,            0,0,0,0,0);
        tv[19] = mk(0,0,0,        1,2,1, 0,0,0,            0,1,1,'h30,0);
        tv[20] = mk(0,0,0,        0,0,0, 0,0,0,            1,0,0,0,0);
        tv[21] = mk(1,1,'h12AB,   0,0,0, 0,0,0,            1,0,0,0,0);
        tv[22] = mk(0,0,0,        0,0,0, 1,'h1200,'hFF00,  0,0,0,0,1);
        tv[23] = mk(0,0,0,        1,1,1, 1,'h1200,'hFF00,  0,1,1,'h12AB,1);
        tv[24] = mk(0,0,0,        0,0,0, 1,'h1200,'hFF00,  1,0,0,0,0);
        tv[25] = mk(1,3,'h40,     1,2,1, 0,0,0,            1,0,0,0,0);
        tv[26] = mk(0,0,0,        1,3,0, 0,0,0,            0,1,1,'h40,0);
        tv[27] = mk(0,0,0,        1,2,0, 0,0,0,            0,1,1,'h31,0);

        do_reset();

        for (int i = 0; i < 28; i++) begin
            inp_req = tv[i].ireq; inp_id = tv[i].iid; inp_data = tv[i].idata;
            oup_req = tv[i].oreq; oup_id = tv[i].oid; oup_pop = tv[i].pop;
            ex_req = tv[i].ereq; ex_data = tv[i].edata; ex_mask = tv[i].emask;
            @(negedge clk);
            chk($sformatf("vec%0d.inp_gnt", i), {31'd0, igt0}, {31'd0, tv[i].e_igt});
            chk($sformatf("vec%0d.oup_gnt", i), {31'd0, ogt0}, {31'd0, tv[i].e_ogt});
            chk($sformatf("vec%0d.valid", i), {31'd0, vld0}, {31'd0, tv[i].e_vld});
            chk($sformatf("vec%0d.data", i), od0, tv[i].e_od);
            chk($sformatf("vec%0d.exists", i), {31'd0, ex0}, {31'd0, tv[i].e_ex});
            check_model($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // Full queue, same-cycle push and pop of a single-element ID.
        do_reset();
        for (int k = 0; k < 4; k++) push_one(2'(k), 32'h50 + k);
        idle_inputs();
        inp_req = 1'b1; inp_id = 2'd3; inp_data = 32'h77;
        oup_req = 1'b1; oup_id = 2'd3; oup_pop = 1'b1;
        @(negedge clk);
        chk("fullbw.inp_gnt1", {31'd0, igt1}, 32'd1);
        chk("fullbw.inp_gnt0", {31'd0, igt0}, 32'd0);
        chk("fullbw.pop_data1", od1, 32'h53);
        check_model("fullbw.swap");
        @(posedge clk);
        #1;
        idle_inputs();
        oup_req = 1'b1; oup_id = 2'd3;
        @(negedge clk);
        chk("fullbw.read_valid1", {31'd0, vld1}, 32'd1);
        chk("fullbw.read_data1", od1, 32'h77);
        chk("fullbw.read_valid0", {31'd0, vld0}, 32'd0);
        chk("fullbw.full_again1", {31'd0, igt1}, 32'd0);
        check_model("fullbw.read");
        @(posedge clk);
        #1;

        // Reset in the middle of operation, asserted away from the clock edge.
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        oup_req = 1'b1; oup_id = 2'd0; ex_req = 1'b1; ex_mask = 32'd0;
        #1;
        chk("midreset.valid0", {31'd0, vld0}, 32'd0);
        chk("midreset.valid1", {31'd0, vld1}, 32'd0);
        chk("midreset.exists1", {31'd0, ex1}, 32'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            inp_req  = ($urandom_range(0, 99) < 55);
            inp_id   = 2'($urandom_range(0, 3));
            inp_data = $urandom_range(0, 31) | ($urandom_range(0, 3) << 12);
            oup_req  = ($urandom_range(0, 99) < 60);
            oup_id   = 2'($urandom_range(0, 3));
            oup_pop  = ($urandom_range(0, 99) < 70);
            ex_req   = ($urandom_range(0, 1) == 1);
            ex_data  = $urandom_range(0, 31) | ($urandom_range(0, 3) << 12);
            case ($urandom_range(0, 3))
                0:       ex_mask = 32'hFFFF_FFFF;
                1:       ex_mask = 32'h0000_F000;
                2:       ex_mask = 32'h0000_0007;
                default: ex_mask = $urandom;
            endcase
            step($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
